// File: rtl/operand_collector_pkg.sv
// Shared constants and types for the operand collector and adder tree.
// Lane k of a flat vector sits at bits [k*DATA_W +: DATA_W].
package operand_collector_pkg;

  localparam int DATA_W  = 8;
  localparam int NUM_OPS = 8;
  localparam int IDX_W   = 3;
  localparam int CNT_W   = IDX_W + 1;
  localparam int VEC_W   = NUM_OPS * DATA_W;

  typedef logic [NUM_OPS-1:0][DATA_W-1:0] lanes_t;
  typedef logic [IDX_W-1:0]               idx_t;
  typedef logic [CNT_W-1:0]               cnt_t;

  function automatic cnt_t lane_count(
    input idx_t idx
  );
    return cnt_t'(idx) + cnt_t'(1);
  endfunction

  function automatic logic [DATA_W-1:0] lane_of(
    input logic [VEC_W-1:0] vec,
    input int               k
  );
    return vec[k*DATA_W +: DATA_W];
  endfunction

endpackage

// File: rtl/operand_collector_bank.sv
// One NUM_OPS x DATA_W operand bank with lane write, count latch, clear.
// Ports: wr_en_i/wr_idx_i/wr_data_i, close_i/cnt_i, clr_i -> lanes_o, cnt_o.
module operand_collector_bank
  import operand_collector_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en_i,
  input  idx_t              wr_idx_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              close_i,
  input  cnt_t              cnt_i,
  input  logic              clr_i,
  output logic [VEC_W-1:0]  lanes_o,
  output cnt_t              cnt_o
);

  lanes_t lanes_q;
  cnt_t   cnt_q;

  // Clearing on release keeps unwritten lanes of a short vector at 0.
  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) begin
      lanes_q <= '0;
      cnt_q   <= '0;
    end else begin
      if (wr_en_i) lanes_q[wr_idx_i] <= wr_data_i;
      if (close_i) cnt_q <= cnt_i;
    end
  end

  assign lanes_o = lanes_q;
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/operand_collector.sv
// Ping-pong collector: serial operands in, 8-lane vectors out (valid/ready).
// Ports: s_valid/s_ready/s_data/s_last in, m_valid/m_ready/m_operands/m_count out.
module operand_collector
  import operand_collector_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [VEC_W-1:0]  m_operands,
  output cnt_t              m_count
);

  logic       wr_sel_q, wr_sel_d;
  logic       rd_sel_q, rd_sel_d;
  logic [1:0] full_q, full_d;
  idx_t       wr_idx_q, wr_idx_d;

  logic       accept;
  logic       close;
  logic       release_v;

  logic [VEC_W-1:0] lanes_w [2];
  cnt_t             cnt_w   [2];

  assign s_ready   = rst_n && !full_q[wr_sel_q];
  assign m_valid   = rst_n && full_q[rd_sel_q];
  assign accept    = s_valid && s_ready;
  assign close     = accept &&
                     (s_last || wr_idx_q == idx_t'(NUM_OPS-1));
  assign release_v = m_valid && m_ready;

  assign m_operands = rst_n ? lanes_w[rd_sel_q] : '0;
  assign m_count    = rst_n ? cnt_w[rd_sel_q]   : '0;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    operand_collector_bank u_bank (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en_i   (accept && (wr_sel_q == 1'(b))),
      .wr_idx_i  (wr_idx_q),
      .wr_data_i (s_data),
      .close_i   (close && (wr_sel_q == 1'(b))),
      .cnt_i     (lane_count(wr_idx_q)),
      .clr_i     (release_v && (rd_sel_q == 1'(b))),
      .lanes_o   (lanes_w[b]),
      .cnt_o     (cnt_w[b])
    );
  end

  // Close and release always target different banks, so both may apply.
  always_comb begin
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    full_d   = full_q;
    wr_idx_d = wr_idx_q;
    if (accept) wr_idx_d = wr_idx_q + idx_t'(1);
    if (close) begin
      full_d[wr_sel_q] = 1'b1;
      wr_idx_d         = '0;
      wr_sel_d         = ~wr_sel_q;
    end
    if (release_v) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = ~rd_sel_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      full_q   <= '0;
      wr_idx_q <= '0;
    end else begin
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      full_q   <= full_d;
      wr_idx_q <= wr_idx_d;
    end
  end

endmodule

// File: tb/tb_operand_collector.sv
// Bench for operand_collector: directed scenarios plus random traffic
// against a queue-based model of closed-but-undelivered vectors.
module tb_operand_collector;
  import operand_collector_pkg::*;

  typedef struct packed {
    logic [VEC_W-1:0] ops;
    cnt_t             cnt;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              m_valid;
  logic              m_ready;
  logic [VEC_W-1:0]  m_operands;
  cnt_t              m_count;

  int errors = 0;
  int checks = 0;

  vec_t exp_q[$];
  vec_t log_q[$];
  logic [VEC_W-1:0] part_ops;
  int part_n;
  int produced;

  operand_collector dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_operands (m_operands),
    .m_count    (m_count)
  );

  always #5 clk = ~clk;

  // Scoreboard: exp_q holds vectors that are closed but not yet taken,
  // so the collector is ready iff fewer than two are waiting.
  always @(negedge clk) begin
    logic exp_rdy;
    logic exp_val;
    if (!rst_n) begin
      exp_q.delete();
      part_ops = '0;
      part_n   = 0;
    end else begin
      exp_rdy = exp_q.size() < 2;
      exp_val = exp_q.size() != 0;
      checks++;
      if (s_ready !== exp_rdy) begin
        errors++;
        $display("FAIL s_ready t=%0t got=%b exp=%b",
                 $time, s_ready, exp_rdy);
      end
      checks++;
      if (m_valid !== exp_val) begin
        errors++;
        $display("FAIL m_valid t=%0t got=%b exp=%b",
                 $time, m_valid, exp_val);
      end
      if (exp_val) begin
        checks++;
        if (m_operands !== exp_q[0].ops ||
            m_count !== exp_q[0].cnt) begin
          errors++;
          $display("FAIL vector t=%0t got=%h/%0d exp=%h/%0d",
                   $time, m_operands, m_count,
                   exp_q[0].ops, exp_q[0].cnt);
        end
        if (m_ready) begin
          log_q.push_back('{m_operands, m_count});
          void'(exp_q.pop_front());
        end
      end
      if (s_valid && exp_rdy) begin
        part_ops[part_n*DATA_W +: DATA_W] = s_data;
        part_n++;
        if (part_n == NUM_OPS || s_last) begin
          exp_q.push_back('{part_ops, cnt_t'(part_n)});
          produced++;
          part_ops = '0;
          part_n   = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DATA_W-1:0] d,
                      input logic l);
    logic rdy;
    int n;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    n = 0;
    do begin
      @(negedge clk);
      rdy = s_ready;
      tick();
      n++;
    end while (!rdy && n < 200);
    if (!rdy) begin
      errors++;
      $display("FAIL send_timeout data=%0d", d);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_log(input int n);
    int c;
    c = 0;
    while (log_q.size() < n && c < 100) begin
      tick();
      c++;
    end
    checks++;
    if (log_q.size() < n) begin
      errors++;
      $display("FAIL wait_log got=%0d exp=%0d", log_q.size(), n);
    end
  endtask

  function automatic int vsum(input vec_t v);
    int s;
    s = 0;
    for (int k = 0; k < NUM_OPS; k++)
      s += int'(lane_of(v.ops, k));
    return s;
  endfunction

  task automatic test_reset();
    rst_n   = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'hAA;
    s_last  = 1'b1;
    m_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b0 || m_valid !== 1'b0 ||
        m_operands !== '0 || m_count !== '0) begin
      errors++;
      $display("FAIL reset_outputs rdy=%b val=%b ops=%h cnt=%0d exp=0",
               s_ready, m_valid, m_operands, m_count);
    end
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_exit rdy=%b val=%b exp=1/0",
               s_ready, m_valid);
    end
    tick();
  endtask

  task automatic test_single();
    log_q.delete();
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
    wait_log(1);
    checks++;
    if (log_q.size() != 1 || log_q[0].cnt !== cnt_t'(8) ||
        lane_of(log_q[0].ops, 0) !== 8'd1 ||
        lane_of(log_q[0].ops, 7) !== 8'd8) begin
      errors++;
      $display("FAIL single n=%0d got=%h", log_q.size(),
               log_q.size() ? log_q[0].ops : '0);
    end
  endtask

  task automatic test_back_to_back();
    log_q.delete();
    m_ready = 1'b1;
    for (int i = 1; i <= 16; i++) send(8'(i), 1'b0);
    wait_log(2);
    checks++;
    if (log_q.size() != 2 || vsum(log_q[0]) != 36 ||
        vsum(log_q[1]) != 100) begin
      errors++;
      $display("FAIL b2b_sums n=%0d exp=36,100", log_q.size());
    end
  endtask

  task automatic test_short();
    log_q.delete();
    m_ready = 1'b1;
    send(8'h10, 1'b0);
    send(8'h20, 1'b0);
    send(8'h30, 1'b1);
    wait_log(1);
    checks++;
    if (log_q.size() != 1 ||
        log_q[0].ops !== 64'h0000_0000_0030_2010 ||
        log_q[0].cnt !== cnt_t'(3)) begin
      errors++;
      $display("FAIL short got=%h/%0d exp=302010/3",
               log_q.size() ? log_q[0].ops : '0,
               log_q.size() ? log_q[0].cnt : '0);
    end
  endtask

  task automatic test_backpressure();
    log_q.delete();
    m_ready = 1'b0;
    for (int i = 1; i <= 16; i++) send(8'(i), 1'b0);
    s_valid = 1'b1;
    s_data  = 8'd17;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (s_ready !== 1'b0 || log_q.size() != 0) begin
        errors++;
        $display("FAIL bp_hold rdy=%b n=%0d exp=0/0",
                 s_ready, log_q.size());
      end
      tick();
    end
    m_ready = 1'b1;
    send(8'd17, 1'b0);
    for (int i = 18; i <= 20; i++) send(8'(i), i == 20);
    wait_log(3);
    checks++;
    if (log_q.size() != 3 || vsum(log_q[0]) != 36 ||
        vsum(log_q[1]) != 100 ||
        lane_of(log_q[2].ops, 0) !== 8'd17 ||
        log_q[2].cnt !== cnt_t'(4)) begin
      errors++;
      $display("FAIL bp_order n=%0d", log_q.size());
    end
  endtask

  task automatic test_reset_mid();
    log_q.delete();
    m_ready = 1'b1;
    for (int i = 1; i <= 5; i++) send(8'(40 + i), 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
    wait_log(1);
    repeat (3) tick();
    checks++;
    if (log_q.size() != 1 || vsum(log_q[0]) != 36 ||
        log_q[0].cnt !== cnt_t'(8)) begin
      errors++;
      $display("FAIL reset_mid n=%0d", log_q.size());
    end
  endtask

  task automatic test_hold();
    logic [VEC_W-1:0] ops0;
    cnt_t cnt0;
    log_q.delete();
    m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) send(8'(i * 3), 1'b0);
    @(negedge clk);
    ops0 = m_operands;
    cnt0 = m_count;
    tick();
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b1 || m_operands !== ops0 ||
          m_count !== cnt0) begin
        errors++;
        $display("FAIL hold val=%b ops=%h exp=%h",
                 m_valid, m_operands, ops0);
      end
      tick();
    end
    m_ready = 1'b1;
    repeat (4) tick();
    checks++;
    if (log_q.size() != 1 || vsum(log_q[0]) != 108) begin
      errors++;
      $display("FAIL hold_xfer n=%0d exp=1", log_q.size());
    end
  endtask

  task automatic test_random();
    int base;
    base = produced;
    log_q.delete();
    repeat (400) begin
      s_valid = ($urandom_range(3) != 0);
      s_data  = 8'($urandom);
      s_last  = ($urandom_range(5) == 0);
      m_ready = ($urandom_range(2) != 0);
      tick();
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    send(8'($urandom), 1'b1);
    repeat (10) tick();
    checks++;
    if (log_q.size() != produced - base || exp_q.size() != 0) begin
      errors++;
      $display("FAIL random_drain got=%0d exp=%0d",
               log_q.size(), produced - base);
    end
  endtask

  initial begin
    produced = 0;
    part_ops = '0;
    part_n   = 0;
    s_valid  = 1'b0;
    s_data   = '0;
    s_last   = 1'b0;
    m_ready  = 1'b0;
    rst_n    = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_short();
    test_backpressure();
    test_reset_mid();
    test_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
